// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS out, one response per command.
// Build option: define APB_MASTER_TIMEOUT_EN to bound ACCESS wait states to TIMEOUT_CYCLES.
//
// state  | meaning
// IDLE   | no transfer; cmd_ready high, accept next command
// SETUP  | psel=1 penable=0, address/direction/data presented
// ACCESS | psel=1 penable=1, waiting for pready (or timeout)
module apb_master_bridge #(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  pwrite,
   output logic                  psel,
   output logic                  penable,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   localparam logic [7:0] TO_CFG = 8'(TIMEOUT_CYCLES);

   state_t state;

   assign cmd_ready = (state == S_IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
   // wait_cnt holds the number of pready-low ACCESS cycles already seen
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wait_cnt;
`else
   logic unused_cfg;
   assign unused_cfg = ^TO_CFG;
   assign rsp_err    = 1'b0;
`endif

   always_ff @(posedge pclk) begin
      if (PRESET) begin
         state     <= S_IDLE;
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
         rsp_err   <= 1'b0;
         wait_cnt  <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  paddr   <= cmd_addr;
                  pwrite  <= cmd_write;
                  pwdata  <= cmd_write ? cmd_wdata : '0;
                  psel    <= 1'b1;
                  penable <= 1'b0;
                  state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               penable  <= 1'b1;
               state    <= S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            S_ACCESS: begin
               if (pready) begin
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= pwrite ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
                  rsp_err   <= 1'b0;
`endif
                  state     <= S_IDLE;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (wait_cnt == TO_LAST) begin
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  wait_cnt  <= wait_cnt + 8'd1;
               end
`endif
            end
            default: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
